// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UARTsv transmit and receive paths.
// Frame: start bit, data MSB first, even parity, stop bits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_STOP_BITS = 2;
    localparam int FRAME_BITS    = 2 + DEF_DATA_BITS + DEF_STOP_BITS;
    localparam int MAX_DATA_BITS = 32;

    // Zero-extension of the argument leaves the XOR unchanged.
    function automatic logic even_parity(
        input logic [MAX_DATA_BITS-1:0] d
    );
        return ^d;
    endfunction

    function automatic int frame_bits(
        input int data_bits,
        input int stop_bits
    );
        return 2 + data_bits + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous word FIFO feeding the UART transmitter.
// Full/empty decode the registered count; writes while full are dropped.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_wr,
    input  logic [DATA_BITS-1:0]              i_wr_data,
    input  logic                              i_pop,
    output logic [DATA_BITS-1:0]              o_rd_data,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
    output logic                              o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;
    logic                 w_push;
    logic                 w_pop;

    assign o_full  = (r_count == CW'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_wr && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_wr && o_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: transmit half of the UARTsv core.
// FIFO-buffered, CTS-gated serialiser with its own baud divider.
module uart_tx
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 4,
    parameter int BAUD_RATE   = 1,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                            SysClk,
    input  logic                            Rst,
    input  logic [DATA_BITS-1:0]            Tx_Data,
    input  logic                            Tx_Write,
    input  logic                            CTS,
    output logic                            Tx,
    output logic                            Tx_Busy,
    output logic                            Tx_Full,
    output logic                            Tx_Empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] Tx_Count,
    output logic                            Overflow
);

    localparam int DIV = SYSCLK_RATE / BAUD_RATE;
    localparam int DW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [DW-1:0]        r_div;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_par;
    logic                 w_par_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_pop;
    logic                 w_tick;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic                 w_can_start;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_overflow;
    logic [CW-1:0]        w_count;

    uart_tx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (SysClk),
        .i_rst_n    (Rst),
        .i_wr       (Tx_Write),
        .i_wr_data  (Tx_Data),
        .i_pop      (w_pop),
        .o_rd_data  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_overflow (w_overflow)
    );

    assign w_tick      = (r_div == DW'(DIV - 1));
    assign w_last_data = (r_bit == BW'(DATA_BITS - 1));
    assign w_last_stop = (r_bit == BW'(STOP_BITS - 1));
    assign w_can_start = !w_empty && CTS;

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // CTS is only consulted where a new frame could begin.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_can_start) begin
                    w_state_next = START;
                    w_pop        = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick && w_last_data) begin
                    w_state_next = PARITY;
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_tick && w_last_stop) begin
                    if (w_can_start) begin
                        w_state_next = START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_shift_next = r_shift;
        w_par_next   = r_par;
        if (w_pop) begin
            w_shift_next = w_head;
            w_par_next   = even_parity(MAX_DATA_BITS'(w_head));
        end else if (r_state == DATA && w_tick && !w_last_data) begin
            w_shift_next = {r_shift[DATA_BITS-2:0], 1'b0};
        end
    end

    // Line level is computed for the state being entered, then registered.
    always_comb begin
        w_tx_next = 1'b1;
        unique case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[DATA_BITS-1];
            PARITY:  w_tx_next = w_par_next;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_shift <= w_shift_next;
            r_par   <= w_par_next;
            r_tx    <= w_tx_next;
            if (r_state == IDLE || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DW'(1);
            end
            if (w_state_next != r_state) begin
                r_bit <= '0;
            end else if (w_tick) begin
                r_bit <= r_bit + BW'(1);
            end
        end
    end

    assign Tx       = r_tx;
    assign Tx_Busy  = (r_state != IDLE);
    assign Tx_Full  = w_full;
    assign Tx_Empty = w_empty;
    assign Tx_Count = w_count;
    assign Overflow = w_overflow;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with default parameters.
// Directed vectors, corner-case sequences and a random scoreboard run.
module tb_uart_tx;

    localparam int DIV = 4;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic       SysClk   = 1'b0;
    logic       Rst      = 1'b0;
    logic       Tx_Write = 1'b0;
    logic       CTS      = 1'b0;
    logic [7:0] Tx_Data  = 8'h00;
    logic       Tx;
    logic       Tx_Busy;
    logic       Tx_Full;
    logic       Tx_Empty;
    logic [3:0] Tx_Count;
    logic       Overflow;

    int n_checks = 0;
    int n_errors = 0;

    vec_t tbl [9];

    always #5 SysClk = ~SysClk;

    uart_tx dut (
        .SysClk   (SysClk),
        .Rst      (Rst),
        .Tx_Data  (Tx_Data),
        .Tx_Write (Tx_Write),
        .CTS      (CTS),
        .Tx       (Tx),
        .Tx_Busy  (Tx_Busy),
        .Tx_Full  (Tx_Full),
        .Tx_Empty (Tx_Empty),
        .Tx_Count (Tx_Count),
        .Overflow (Overflow)
    );

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic checkv(input string nm, input logic [399:0] act,
                          input logic [399:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line waveform of one frame, one sample per clock, earliest in the MSB.
    function automatic logic [47:0] frame_vec(input logic [7:0] w);
        logic [47:0] v;
        logic        b;
        v = '0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0)      b = 1'b0;
            else if (k <= 8) b = w[8-k];
            else if (k == 9) b = ^w;
            else             b = 1'b1;
            for (int c = 0; c < DIV; c++) v = {v[46:0], b};
        end
        return v;
    endfunction

    task automatic step();
        @(negedge SysClk);
    endtask

    task automatic sample(input int n, output logic [399:0] tv,
                          output logic [399:0] bv);
        tv = '0;
        bv = '0;
        for (int i = 0; i < n; i++) begin
            tv = {tv[398:0], Tx};
            bv = {bv[398:0], Tx_Busy};
            @(negedge SysClk);
        end
    endtask

    task automatic do_reset();
        Rst      = 1'b0;
        Tx_Write = 1'b0;
        CTS      = 1'b0;
        Tx_Data  = 8'h00;
        repeat (3) @(negedge SysClk);
        Rst = 1'b1;
        @(negedge SysClk);
    endtask

    initial begin
        logic [399:0] tv, bv, ev;
        logic [47:0]  fv, cap;
        logic [7:0]   q [$];
        logic [7:0]   d_data;
        logic         d_wr, d_cts, es, acc, eo, eb;
        int           m_cnt, mon, w;

        tbl[0] = '{8'hA5, 1'b0};
        tbl[1] = '{8'h01, 1'b1};
        tbl[2] = '{8'hFF, 1'b0};
        tbl[3] = '{8'h3C, 1'b0};
        tbl[4] = '{8'h80, 1'b1};
        tbl[5] = '{8'h7E, 1'b0};
        tbl[6] = '{8'h00, 1'b0};
        tbl[7] = '{8'h55, 1'b0};
        tbl[8] = '{8'h07, 1'b1};

        #12;
        check1("reset Tx", Tx, 1'b1);
        check1("reset Busy", Tx_Busy, 1'b0);
        check1("reset Full", Tx_Full, 1'b0);
        check1("reset Empty", Tx_Empty, 1'b1);
        checki("reset Count", int'(Tx_Count), 0);
        check1("reset Overflow", Overflow, 1'b0);
        do_reset();

        // Single words: latency, frame shape, parity, busy window
        CTS = 1'b1;
        for (int i = 0; i < 9; i++) begin
            Tx_Data  = tbl[i].data;
            Tx_Write = 1'b1;
            step();
            Tx_Write = 1'b0;
            sample(50, tv, bv);
            ev = {350'b0, 1'b1, frame_vec(tbl[i].data), 1'b1};
            checkv("single frame", tv, ev);
            checkv("single busy", bv, {350'b0, 1'b0, {48{1'b1}}, 1'b0});
            check1("single parity", tv[11], tbl[i].par);
            step();
        end

        // Back-to-back frames with no idle gap
        do_reset();
        CTS      = 1'b1;
        Tx_Data  = 8'h01;
        Tx_Write = 1'b1;
        step();
        Tx_Data = 8'hFF;
        step();
        Tx_Write = 1'b0;
        sample(97, tv, bv);
        checkv("b2b frames", tv,
               {303'b0, frame_vec(8'h01), frame_vec(8'hFF), 1'b1});

        // Fill, overflow, then drain in order
        do_reset();
        for (int i = 0; i < 8; i++) begin
            Tx_Data  = 8'(i);
            Tx_Write = 1'b1;
            step();
        end
        checki("fill Count", int'(Tx_Count), 8);
        check1("fill Full", Tx_Full, 1'b1);
        check1("fill Empty", Tx_Empty, 1'b0);
        check1("fill idle Tx", Tx, 1'b1);
        Tx_Data = 8'h08;
        step();
        Tx_Write = 1'b0;
        check1("ovf pulse", Overflow, 1'b1);
        checki("ovf Count", int'(Tx_Count), 8);
        step();
        check1("ovf one cycle", Overflow, 1'b0);
        CTS = 1'b1;
        step();
        sample(384, tv, bv);
        ev = '0;
        for (int k = 0; k < 8; k++) ev = {ev[351:0], frame_vec(8'(k))};
        checkv("drain frames", tv, ev);
        check1("drain Tx idle", Tx, 1'b1);
        check1("drain Busy", Tx_Busy, 1'b0);
        check1("drain Empty", Tx_Empty, 1'b1);

        // CTS gating
        do_reset();
        Tx_Data  = 8'h3C;
        Tx_Write = 1'b1;
        step();
        Tx_Write = 1'b0;
        sample(200, tv, bv);
        checkv("cts hold Tx", tv, {200'b0, {200{1'b1}}});
        checkv("cts hold Busy", bv, '0);
        CTS = 1'b1;
        step();
        w = 0;
        while (Tx !== 1'b0 && w < 2) begin
            step();
            w++;
        end
        check1("cts start bit", Tx, 1'b0);
        cap = '0;
        for (int c = 0; c < 48; c++) begin
            cap = {cap[46:0], Tx};
            Tx_Write = (c == 5);
            Tx_Data  = 8'h99;
            if (c == 17) CTS = 1'b0;
            step();
        end
        checkv("cts frame", 400'(cap), 400'(frame_vec(8'h3C)));
        sample(100, tv, bv);
        checkv("cts no restart", tv, {300'b0, {100{1'b1}}});
        checki("cts pending", int'(Tx_Count), 1);

        // Asynchronous reset mid-frame
        do_reset();
        CTS      = 1'b1;
        Tx_Data  = 8'h5A;
        Tx_Write = 1'b1;
        step();
        Tx_Data = 8'hC3;
        step();
        Tx_Write = 1'b0;
        repeat (21) step();
        fv = frame_vec(8'h5A);
        check1("pre-rst Busy", Tx_Busy, 1'b1);
        check1("pre-rst Tx", Tx, fv[26]);
        checki("pre-rst Count", int'(Tx_Count), 1);
        #2 Rst = 1'b0;
        #1;
        check1("async rst Tx", Tx, 1'b1);
        check1("async rst Busy", Tx_Busy, 1'b0);
        checki("async rst Count", int'(Tx_Count), 0);
        check1("async rst Empty", Tx_Empty, 1'b1);
        @(negedge SysClk);
        Rst = 1'b1;
        step();
        sample(150, tv, bv);
        checkv("post-rst Tx", tv, {250'b0, {150{1'b1}}});
        checkv("post-rst Busy", bv, '0);

        // Write against a full FIFO in the cycle that pops
        do_reset();
        CTS      = 1'b1;
        Tx_Data  = 8'hE1;
        Tx_Write = 1'b1;
        cap      = '0;
        for (int t = 1; t <= 97; t++) begin
            step();
            if (t == 20) begin
                checki("sim full Count", int'(Tx_Count), 8);
                check1("sim Full", Tx_Full, 1'b1);
            end
            if (t == 49) begin
                check1("sim last stop", Tx, 1'b1);
                check1("sim busy", Tx_Busy, 1'b1);
            end
            if (t == 50) begin
                check1("sim ovf", Overflow, 1'b1);
                checki("sim Count", int'(Tx_Count), 7);
            end
            if (t == 51) check1("sim ovf end", Overflow, 1'b0);
            if (t >= 50) cap = {cap[46:0], Tx};
            Tx_Write = (t <= 8) || (t == 49);
            Tx_Data  = (t == 49) ? 8'h77 : 8'(16 + t - 1);
        end
        checkv("sim next frame", 400'(cap), 400'(frame_vec(8'h10)));

        // Random traffic against a queue scoreboard
        do_reset();
        q.delete();
        m_cnt  = 0;
        mon    = 0;
        d_wr   = 1'b0;
        d_cts  = 1'b0;
        d_data = 8'h00;
        cap    = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            es  = (mon == 0) && (m_cnt > 0) && d_cts;
            acc = d_wr && (m_cnt < 8);
            eo  = d_wr && (m_cnt == 8);
            if (acc) q.push_back(d_data);
            m_cnt = m_cnt + int'(acc) - int'(es);
            eb    = es || (mon != 0);
            if (mon == 0) begin
                check1("rnd idle/start", Tx, !es);
                if (es) begin
                    cap = {47'b0, Tx};
                    mon = 1;
                end
            end else begin
                cap = {cap[46:0], Tx};
                mon++;
                if (mon == 48) begin
                    checki("rnd frame queued", int'(q.size() > 0), 1);
                    if (q.size() > 0)
                        checkv("rnd frame", 400'(cap),
                               400'(frame_vec(q.pop_front())));
                    mon = 0;
                end
            end
            check1("rnd Busy", Tx_Busy, eb);
            check1("rnd Overflow", Overflow, eo);
            checki("rnd Count", int'(Tx_Count), m_cnt);
            check1("rnd Empty", Tx_Empty, m_cnt == 0);
            if (n_errors > 20) break;
            d_wr   = (cyc < 3000) && ($urandom_range(0, 15) == 0);
            d_data = 8'($urandom);
            if ($urandom_range(0, 99) == 0) d_cts = !d_cts;
            if (cyc >= 3000) d_cts = 1'b1;
            Tx_Write = d_wr;
            Tx_Data  = d_data;
            CTS      = d_cts;
        end
        checki("rnd drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
